// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential ALU (alu_seq).
// The divider datapath is only built when ALU_SEQ_DIV_EN is defined.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_ORR  = 4'b0011,
    OP_EOR  = 4'b0100,
    OP_ADC  = 4'b0101,
    OP_SBC  = 4'b0110,
    OP_BIC  = 4'b0111,
    OP_MUL  = 4'b1000,
    OP_UDIV = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative datapath: shift-add multiply and restoring unsigned divide.
// One iteration per step_i; result_o is the value the register set would
// hold after the current step, so the caller can capture it on the last one.
// The divide half exists only when ALU_SEQ_DIV_EN is defined.
module alu_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             op_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o
);

  // acc: product accumulator / partial remainder
  // opb: multiplier (shifted right) / dividend-then-quotient (shifted left)
  // opc: multiplicand (shifted left) / divisor (constant)
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] opc_q, opc_d;
  logic [WIDTH-1:0] mul_acc_s;
  logic             div_sel_s;
  logic             load_div_s;
  logic [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0] quot_s;

`ifdef ALU_SEQ_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;

  assign div_sel_s  = div_q;
  assign load_div_s = op_div_i;

  // Restoring divide step: shift {rem,quot} left, keep the trial difference if it did not go negative
  always_comb begin
    shifted_s = {acc_q, opb_q[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, opc_q};
    if (trial_s[WIDTH] == 1'b0) begin
      rem_s  = trial_s[WIDTH-1:0];
      quot_s = {opb_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_s  = shifted_s[WIDTH-1:0];
      quot_s = {opb_q[WIDTH-2:0], 1'b0};
    end
  end

  // Remember which operation the loaded operands belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= 1'b0;
    end else if (start_i) begin
      div_q <= op_div_i;
    end else begin
      div_q <= div_q;
    end
  end
`else
  logic unused_div_s;

  assign unused_div_s = op_div_i;
  assign div_sel_s    = 1'b0;
  assign load_div_s   = 1'b0;
  assign rem_s        = '0;
  assign quot_s       = '0;
`endif

  // Shift-add multiply step: add the multiplicand when the current multiplier bit is set
  always_comb begin
    mul_acc_s = acc_q + (opb_q[0] ? opc_q : '0);
  end

  // Next-state selection: load on start, iterate on step, otherwise hold
  always_comb begin
    acc_d = acc_q;
    opb_d = opb_q;
    opc_d = opc_q;
    if (start_i) begin
      acc_d = '0;
      opb_d = load_div_s ? a_i : b_i;
      opc_d = load_div_s ? b_i : a_i;
    end else if (step_i) begin
      if (div_sel_s) begin
        acc_d = rem_s;
        opb_d = quot_s;
        opc_d = opc_q;
      end else begin
        acc_d = mul_acc_s;
        opb_d = {1'b0, opb_q[WIDTH-1:1]};
        opc_d = {opc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = acc_q;
    end
    result_o = div_sel_s ? quot_s : mul_acc_s;
  end

  // Iteration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      opb_q <= '0;
      opc_q <= '0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
      opc_q <= opc_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: ARM data-processing ops with NZCV flags in one
// cycle, MUL (and UDIV when ALU_SEQ_DIV_EN is defined) over WIDTH cycles.
// Holds one operation at a time; the result stays put until out_ready.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             init_q;

  logic             start_s, step_s, is_iter_s;
  logic [WIDTH-1:0] iter_res_s;
  logic [WIDTH-1:0] alu_res_s;
  logic [3:0]       alu_flags_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] opb_s;
  logic             cin_s;
  logic             arith_s;

  function automatic logic [3:0] nz_flags(input logic [WIDTH-1:0] res);
    nz_flags         = 4'b0000;
    nz_flags[FLAG_N] = res[WIDTH-1];
    nz_flags[FLAG_Z] = (res == '0);
  endfunction

  // A zero divisor (or a build without the divider) takes the single-cycle path
`ifdef ALU_SEQ_DIV_EN
  assign is_iter_s = (ALUControl == OP_MUL) ||
                     ((ALUControl == OP_UDIV) && (SrcB != '0));
`else
  assign is_iter_s = (ALUControl == OP_MUL);
`endif

  // Single-cycle result and flags; add/sub family shares one WIDTH+1 bit adder
  always_comb begin
    opb_s   = SrcB;
    cin_s   = 1'b0;
    arith_s = 1'b0;
    case (ALUControl)
      OP_ADD:  arith_s = 1'b1;
      OP_SUB:  begin opb_s = ~SrcB; cin_s = 1'b1;     arith_s = 1'b1; end
      OP_ADC:  begin cin_s = carry_in;                arith_s = 1'b1; end
      OP_SBC:  begin opb_s = ~SrcB; cin_s = carry_in; arith_s = 1'b1; end
      default: arith_s = 1'b0;
    endcase
    sum_s = {1'b0, SrcA} + {1'b0, opb_s} + {{WIDTH{1'b0}}, cin_s};
    case (ALUControl)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: alu_res_s = sum_s[WIDTH-1:0];
      OP_AND:  alu_res_s = SrcA & SrcB;
      OP_ORR:  alu_res_s = SrcA | SrcB;
      OP_EOR:  alu_res_s = SrcA ^ SrcB;
      OP_BIC:  alu_res_s = SrcA & ~SrcB;
      default: alu_res_s = '0;
    endcase
    alu_flags_s         = nz_flags(alu_res_s);
    alu_flags_s[FLAG_C] = arith_s & sum_s[WIDTH];
    alu_flags_s[FLAG_V] = arith_s & (SrcA[WIDTH-1] == opb_s[WIDTH-1]) &
                          (sum_s[WIDTH-1] != SrcA[WIDTH-1]);
  end

  // FSM next state, counter and result capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    start_s  = 1'b0;
    step_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && init_q) begin
          if (is_iter_s) begin
            start_s = 1'b1;
            cnt_d   = CNT_W'(WIDTH);
            state_d = BUSY;
          end else begin
            result_d = alu_res_s;
            flags_d  = alu_flags_s;
            state_d  = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        step_s = 1'b1;
        cnt_d  = cnt_q - CNT_W'(1'b1);
        if (cnt_q == CNT_W'(1'b1)) begin
          result_d = iter_res_s;
          flags_d  = nz_flags(iter_res_s);
          state_d  = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and result registers; init_q keeps in_ready low until the first clock after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= 4'b0000;
      init_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      init_q   <= 1'b1;
    end
  end

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (reset_n),
    .start_i  (start_s),
    .step_i   (step_s),
    .op_div_i (ALUControl == OP_UDIV),
    .a_i      (SrcA),
    .b_i      (SrcB),
    .result_o (iter_res_s)
  );

  assign in_ready  = init_q && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign ALUResult = result_q;
  assign ALUFlags  = flags_q;

endmodule
